mem_rd_axi_master: RTL and testbench
====================================

MEM_RD_AXI_MASTER -- requirements
Module: mem_rd_axi_master

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 64, AXI address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 256, AXI/stream data width; BYTES = C_M_AXI_DATA_WIDTH/8.
REQ-003 Parameter C_XFER_SIZE_WIDTH, default 32, request size width in bytes.
REQ-004 Parameter MAX_BURST_LEN, default 16, max beats per AR burst, power of two, 1..256.
REQ-005 Clock is clk; reset is reset, synchronous, active-high.
REQ-006 Ports: clk in 1 clock; reset in 1 sync reset; fetch_data in 1 request strobe; data_rd_addr in C_M_AXI_ADDR_WIDTH start byte address; data_rd_size in C_XFER_SIZE_WIDTH request bytes; data_read_ready in 1 consumer ready.
REQ-007 Ports: data_in out C_M_AXI_DATA_WIDTH beat data; data_valid out 1 beat qualifier; data_read_done out 1 request-complete pulse; busy out 1; rd_error out 1 sticky error.
REQ-008 AXI ports: m_axi_arvalid out 1; m_axi_arready in 1; m_axi_araddr out C_M_AXI_ADDR_WIDTH; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_rvalid in 1; m_axi_rready out 1; m_axi_rdata in C_M_AXI_DATA_WIDTH; m_axi_rresp in 2; m_axi_rlast in 1.

Function
REQ-009 FSM states IDLE, ADDR, DATA, DONE; fetch_data accepted only in IDLE, ignored otherwise.
REQ-010 On accept: total_beats = ceil(data_rd_size/BYTES); addr latched with low log2(BYTES) bits forced to zero; size 0 -> DONE directly, no AR issued.
REQ-011 ADDR: burst beats = min(remaining beats, MAX_BURST_LEN, beats to next 4 KB boundary); arlen = beats-1; arsize = log2(BYTES); arburst = 2'b01 INCR.
REQ-012 arvalid asserted in ADDR, held with stable araddr/arlen until arready; handshake cycle -> DATA; one burst outstanding at most.
REQ-013 DATA: m_axi_rready = data_read_ready; each rvalid&rready beat registered to data_in with data_valid=1 next cycle, data_valid=0 otherwise (latency 1).
REQ-014 On beat with rlast: address advances by beats*BYTES, remaining decrements; remaining 0 -> DONE else -> ADDR.
REQ-015 DONE: data_read_done=1 for exactly one cycle, -> IDLE; busy=1 in every state but IDLE.
REQ-016 rlast arriving early or late versus computed beat count: burst terminates on rlast, rd_error set.
REQ-017 Remaining/beat counters sized C_XFER_SIZE_WIDTH; address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH.

Reset
REQ-018 Reset: state IDLE, arvalid 0, rready 0, data_valid 0, data_read_done 0, busy 0, rd_error 0, araddr/arlen/data_in 0, arsize/arburst at fixed values.
REQ-019 Reset mid-burst abandons request immediately; in-flight R beats after reset are not accepted (rready 0 until next DATA).
REQ-020 rd_error clears only on reset or on accept of a new fetch_data.

Configuration
REQ-021 Macro MEM_RD_RRESP_CHECK_EN defined: any accepted beat with rresp != 2'b00 sets rd_error.
REQ-022 Macro undefined: rresp ignored; rd_error driven only by REQ-016.

Structure
REQ-023 Shared package mem_test_pkg holds state enum type, AXI burst/resp constants (INCR, OKAY), 4 KB boundary constant.
REQ-024 Sub-module rd_burst_calc (combinational beat-count/4 KB split) natural; all else in one always_ff FSM.

Verification
REQ-025 addr 0x1000, size 32, BYTES 32 -> one AR arlen 0, one data_valid, data_read_done one cycle after beat.
REQ-026 addr 0x0, size 1024, MAX_BURST_LEN 16 -> two ARs 0x0/0x200 arlen 15, 32 beats, single done pulse.
REQ-027 addr 0xFC0, size 256 -> ARs 0xFC0 arlen 1 then 0x1000 arlen 5, no 4 KB crossing.
REQ-028 size 0 -> no arvalid, done pulse 2 cycles after fetch; size 33 -> 2 beats.
REQ-029 data_read_ready toggling 1/0 -> rready follows, no beat lost or duplicated; rresp 2'b10 beat -> rd_error 1 only with MEM_RD_RRESP_CHECK_EN.
REQ-030 reset asserted during DATA -> next cycle all outputs at reset values; new fetch completes normally.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types and constants for the AXI read master: FSM state encoding,
// AXI burst/response codes and the 4 KB boundary that bursts must not cross.
package mem_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/rd_burst_calc.sv
// Combinational burst sizing: the next burst length is the smallest of the
// beats still owed, the configured burst cap, and the beats left before the
// next 4 KB page. Only the in-page address bits matter for the split.
module rd_burst_calc
    import mem_test_pkg::*;
#(
    parameter int SIZE_W        = 32,
    parameter int BYTES         = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0]       addr_low,
    input  logic [SIZE_W-1:0] remaining,
    output logic [SIZE_W-1:0] beats,
    output logic [7:0]        arlen
);

    localparam int LOG_BYTES = $clog2(BYTES);

    logic [12:0]       bytes_to_4k;
    logic [SIZE_W-1:0] beats_to_4k;
    logic [SIZE_W-1:0] cap;

    // Pick the tightest of the three limits and derive AXI arlen from it
    always_comb begin
        bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_low};
        beats_to_4k = SIZE_W'(bytes_to_4k >> LOG_BYTES);
        cap         = (beats_to_4k < SIZE_W'(MAX_BURST_LEN)) ? beats_to_4k : SIZE_W'(MAX_BURST_LEN);
        beats       = (remaining < cap) ? remaining : cap;
        // A 256-beat burst wraps [7:0] to zero, so minus one gives 255
        arlen       = beats[7:0] - 8'd1;
    end

endmodule

// File: rtl/mem_rd_axi_master.sv
// AXI4 read master: turns a (start address, byte count) request into a
// sequence of INCR bursts, one outstanding at a time, and streams each
// returned beat out with one cycle of latency.
// Optional build macro MEM_RD_RRESP_CHECK_EN: non-OKAY rresp sets rd_error.
module mem_rd_axi_master
    import mem_test_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 256,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int MAX_BURST_LEN      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_data,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] data_rd_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  data_rd_size,
    input  logic                          data_read_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_in,
    output logic                          data_valid,
    output logic                          data_read_done,
    output logic                          busy,
    output logic                          rd_error,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast
);

    localparam int ADDR_W    = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W    = C_M_AXI_DATA_WIDTH;
    localparam int SIZE_W    = C_XFER_SIZE_WIDTH;
    localparam int BYTES     = DATA_W / 8;
    localparam int LOG_BYTES = $clog2(BYTES);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [SIZE_W-1:0]   remaining_reg, remaining_next;
    logic [SIZE_W-1:0]   burst_beats_reg, burst_beats_next;
    logic [SIZE_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic                arvalid_reg, arvalid_next;
    logic [ADDR_W-1:0]   araddr_reg, araddr_next;
    logic [7:0]          arlen_reg, arlen_next;
    logic [DATA_W-1:0]   data_in_reg, data_in_next;
    logic                data_valid_reg, data_valid_next;
    logic                done_reg, done_next;
    logic                rd_error_reg, rd_error_next;

    logic [SIZE_W-1:0]   calc_beats;
    logic [7:0]          calc_arlen;
    logic                beat;
    logic                last_expected;
    logic [SIZE_W-1:0]   consumed;

    rd_burst_calc #(
        .SIZE_W        (SIZE_W),
        .BYTES         (BYTES),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_calc (
        .addr_low  (addr_reg[11:0]),
        .remaining (remaining_reg),
        .beats     (calc_beats),
        .arlen     (calc_arlen)
    );

    assign beat          = (state_reg == ST_DATA) && m_axi_rvalid && data_read_ready;
    assign last_expected = (beat_cnt_reg == burst_beats_reg - SIZE_W'(1));
    assign consumed      = beat_cnt_reg + SIZE_W'(1);

`ifndef MEM_RD_RRESP_CHECK_EN
    // Response code is deliberately not consulted in this build
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
`endif

    // Next-state and next-register logic for the request/burst FSM
    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        remaining_next   = remaining_reg;
        burst_beats_next = burst_beats_reg;
        beat_cnt_next    = beat_cnt_reg;
        arvalid_next     = arvalid_reg;
        araddr_next      = araddr_reg;
        arlen_next       = arlen_reg;
        data_in_next     = data_in_reg;
        data_valid_next  = 1'b0;
        done_next        = 1'b0;
        rd_error_next    = rd_error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (fetch_data) begin
                    rd_error_next  = 1'b0;
                    addr_next      = data_rd_addr & ~ADDR_W'(BYTES - 1);
                    remaining_next = (data_rd_size >> LOG_BYTES)
                                   + (((data_rd_size & SIZE_W'(BYTES - 1)) != '0) ? SIZE_W'(1) : '0);
                    state_next     = (data_rd_size == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // First cycle loads the burst, then it is held until accepted
                if (!arvalid_reg) begin
                    arvalid_next     = 1'b1;
                    araddr_next      = addr_reg;
                    arlen_next       = calc_arlen;
                    burst_beats_next = calc_beats;
                end else if (m_axi_arready) begin
                    arvalid_next  = 1'b0;
                    beat_cnt_next = '0;
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    data_in_next    = m_axi_rdata;
                    data_valid_next = 1'b1;
                    beat_cnt_next   = consumed;
`ifdef MEM_RD_RRESP_CHECK_EN
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        rd_error_next = 1'b1;
                    end
`endif
                    if (m_axi_rlast) begin
                        // Burst ends on rlast; account for the beats actually received
                        if (!last_expected) begin
                            rd_error_next = 1'b1;
                        end
                        addr_next = addr_reg + (ADDR_W'(consumed) << LOG_BYTES);
                        if (consumed >= remaining_reg) begin
                            remaining_next = '0;
                            state_next     = ST_DONE;
                        end else begin
                            remaining_next = remaining_reg - consumed;
                            state_next     = ST_ADDR;
                        end
                    end else if (last_expected) begin
                        // Expected final beat arrived without rlast
                        rd_error_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            addr_reg        <= '0;
            remaining_reg   <= '0;
            burst_beats_reg <= '0;
            beat_cnt_reg    <= '0;
            arvalid_reg     <= 1'b0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            data_in_reg     <= '0;
            data_valid_reg  <= 1'b0;
            done_reg        <= 1'b0;
            rd_error_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            remaining_reg   <= remaining_next;
            burst_beats_reg <= burst_beats_next;
            beat_cnt_reg    <= beat_cnt_next;
            arvalid_reg     <= arvalid_next;
            araddr_reg      <= araddr_next;
            arlen_reg       <= arlen_next;
            data_in_reg     <= data_in_next;
            data_valid_reg  <= data_valid_next;
            done_reg        <= done_next;
            rd_error_reg    <= rd_error_next;
        end
    end

    assign m_axi_arvalid  = arvalid_reg;
    assign m_axi_araddr   = araddr_reg;
    assign m_axi_arlen    = arlen_reg;
    assign m_axi_arsize   = 3'(LOG_BYTES);
    assign m_axi_arburst  = AXI_BURST_INCR;
    assign m_axi_rready   = (state_reg == ST_DATA) && data_read_ready;
    assign data_in        = data_in_reg;
    assign data_valid     = data_valid_reg;
    assign data_read_done = done_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign rd_error       = rd_error_reg;

endmodule

// File: tb/tb_mem_rd_axi_master.sv
// Bench for mem_rd_axi_master: an AXI slave/monitor process answers bursts
// with address-derived data; test tasks push expected ARs and beats into
// scoreboard queues and compare them against what the monitor observed.
module tb_mem_rd_axi_master;

    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int SW    = 32;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_data;
    logic [AW-1:0] data_rd_addr;
    logic [SW-1:0] data_rd_size;
    logic          data_read_ready;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_read_done;
    logic          busy;
    logic          rd_error;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;

    mem_rd_axi_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_XFER_SIZE_WIDTH  (SW),
        .MAX_BURST_LEN      (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_data      (fetch_data),
        .data_rd_addr    (data_rd_addr),
        .data_rd_size    (data_rd_size),
        .data_read_ready (data_read_ready),
        .data_in         (data_in),
        .data_valid      (data_valid),
        .data_read_done  (data_read_done),
        .busy            (busy),
        .rd_error        (rd_error),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arlen     (m_axi_arlen),
        .m_axi_arsize    (m_axi_arsize),
        .m_axi_arburst   (m_axi_arburst),
        .m_axi_rvalid    (m_axi_rvalid),
        .m_axi_rready    (m_axi_rready),
        .m_axi_rdata     (m_axi_rdata),
        .m_axi_rresp     (m_axi_rresp),
        .m_axi_rlast     (m_axi_rlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;

    ar_t           obs_ar[$];
    ar_t           exp_ar[$];
    logic [DW-1:0] obs_data[$];
    logic [DW-1:0] exp_data[$];

    int check_cnt   = 0;
    int pass_cnt    = 0;
    int done_cnt    = 0;
    int done_cyc    = 0;
    int dv_last_cyc = 0;
    int fetch_cyc   = 0;
    int rready_viol = 0;

    // Slave model state
    bit            s_active     = 1'b0;
    int            s_idx        = 0;
    int            s_send       = 0;
    logic [AW-1:0] s_addr       = '0;
    int            len_delta    = 0;
    bit            err_inject   = 1'b0;
    bit            toggle_ready = 1'b0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {8{a[31:0] ^ 32'hC3A5_0000}};
    endfunction

    // AXI slave + output monitor: drive on negedge, sample 1 ns later
    initial begin
        m_axi_arready   = 1'b0;
        m_axi_rvalid    = 1'b0;
        m_axi_rdata     = '0;
        m_axi_rresp     = 2'b00;
        m_axi_rlast     = 1'b0;
        data_read_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_axi_arready   = 1'($urandom_range(0, 1));
            data_read_ready = toggle_ready ? ~data_read_ready : 1'b1;
            if (s_active) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = pat(s_addr + AW'(s_idx * BYTES));
                m_axi_rlast  = (s_idx == s_send - 1);
                m_axi_rresp  = (err_inject && s_idx == 0) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata  = '0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
            #1;
            if (reset) begin
                s_active = 1'b0;
                continue;
            end
            if (m_axi_rready !== (s_active & data_read_ready)) rready_viol++;
            if (data_valid === 1'b1) begin
                obs_data.push_back(data_in);
                dv_last_cyc = cyc;
            end
            if (data_read_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                s_idx++;
                if (s_idx == s_send) begin
                    s_active   = 1'b0;
                    err_inject = 1'b0;
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                obs_ar.push_back('{m_axi_araddr, m_axi_arlen});
                s_active  = 1'b1;
                s_idx     = 0;
                s_addr    = m_axi_araddr;
                s_send    = int'(m_axi_arlen) + 1 + len_delta;
                len_delta = 0;
            end
        end
    end

    // Issue one request; optionally wait (bounded) for its completion
    task automatic run_fetch(input logic [AW-1:0] a, input logic [SW-1:0] s, input bit wait_done,
                             output bit busy_ok, output bit done_ok);
        int start;
        start = done_cnt;
        obs_ar.delete();
        obs_data.delete();
        @(negedge clk);
        data_rd_addr = a;
        data_rd_size = s;
        fetch_data   = 1'b1;
        fetch_cyc    = cyc;
        @(negedge clk);
        fetch_data = 1'b0;
        #2;
        busy_ok = (busy === 1'b1);
        done_ok = 1'b1;
        if (wait_done) begin
            for (int i = 0; i < 3000 && done_cnt == start; i++) begin
                @(negedge clk);
                #2;
            end
            repeat (3) @(negedge clk);
            #2;
            done_ok = (done_cnt == start + 1);
        end
        $display("fetch addr=0x%0h size=%0d ars=%0d beats=%0d err=%0b", a, s, obs_ar.size(), obs_data.size(), rd_error);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_cnt++;
        if ({m_axi_arvalid, m_axi_rready, data_valid, data_read_done, busy, rd_error} !== 6'b0)
            $display("FAIL reset_flags got=%b want=000000", {m_axi_arvalid, m_axi_rready, data_valid, data_read_done, busy, rd_error});
        else pass_cnt++;
        check_cnt++;
        if (m_axi_araddr !== '0 || m_axi_arlen !== 8'd0 || data_in !== '0)
            $display("FAIL reset_regs araddr=0x%0h arlen=%0d data_in_nonzero=%0b", m_axi_araddr, m_axi_arlen, |data_in);
        else pass_cnt++;
        check_cnt++;
        if (m_axi_arsize !== 3'd5 || m_axi_arburst !== 2'b01)
            $display("FAIL reset_fixed arsize=%0d arburst=%b want 5/01", m_axi_arsize, m_axi_arburst);
        else pass_cnt++;
    endtask

    task automatic test_single();
        bit b_ok, d_ok;
        ar_t e, o;
        exp_ar.push_back('{64'h1000, 8'd0});
        exp_data.push_back(pat(64'h1000));
        run_fetch(64'h1000, 32, 1'b1, b_ok, d_ok);
        check_cnt++;
        if (!b_ok || !d_ok) $display("FAIL single_busy_done busy_ok=%0b done_ok=%0b want 1/1", b_ok, d_ok);
        else pass_cnt++;
        check_cnt++;
        if (obs_ar.size() != exp_ar.size() || obs_data.size() != exp_data.size())
            $display("FAIL single_counts ars=%0d beats=%0d want %0d/%0d", obs_ar.size(), obs_data.size(), exp_ar.size(), exp_data.size());
        else pass_cnt++;
        while (exp_ar.size() > 0 && obs_ar.size() > 0) begin
            e = exp_ar.pop_front(); o = obs_ar.pop_front();
            check_cnt++;
            if (o.addr !== e.addr || o.len !== e.len) $display("FAIL single_ar got=0x%0h/%0d want=0x%0h/%0d", o.addr, o.len, e.addr, e.len);
            else pass_cnt++;
        end
        while (exp_data.size() > 0 && obs_data.size() > 0) begin
            check_cnt++;
            if (obs_data.pop_front() !== exp_data[0]) $display("FAIL single_data got mismatch want=0x%0h", exp_data[0][31:0]);
            else pass_cnt++;
            void'(exp_data.pop_front());
        end
        check_cnt++;
        if (done_cyc != dv_last_cyc + 1) $display("FAIL single_done_latency got=%0d want=%0d", done_cyc, dv_last_cyc + 1);
        else pass_cnt++;
        exp_ar.delete(); exp_data.delete();
    endtask

    // Multi-burst transfer; expected ARs supplied by the caller's table
    task automatic test_multi(input string name, input logic [AW-1:0] a, input logic [SW-1:0] s,
                              input int nbeats, input bit want_err);
        bit b_ok, d_ok;
        ar_t e, o;
        for (int i = 0; i < nbeats; i++) exp_data.push_back(pat(a + AW'(i * BYTES)));
        run_fetch(a, s, 1'b1, b_ok, d_ok);
        check_cnt++;
        if (!b_ok || !d_ok) $display("FAIL %s_busy_done busy_ok=%0b done_ok=%0b want 1/1", name, b_ok, d_ok);
        else pass_cnt++;
        check_cnt++;
        if (obs_ar.size() != exp_ar.size() || obs_data.size() != exp_data.size())
            $display("FAIL %s_counts ars=%0d beats=%0d want %0d/%0d", name, obs_ar.size(), obs_data.size(), exp_ar.size(), exp_data.size());
        else pass_cnt++;
        while (exp_ar.size() > 0 && obs_ar.size() > 0) begin
            e = exp_ar.pop_front(); o = obs_ar.pop_front();
            check_cnt++;
            if (o.addr !== e.addr || o.len !== e.len) $display("FAIL %s_ar got=0x%0h/%0d want=0x%0h/%0d", name, o.addr, o.len, e.addr, e.len);
            else pass_cnt++;
        end
        check_cnt++;
        begin
            int bad = 0;
            while (exp_data.size() > 0 && obs_data.size() > 0) begin
                if (obs_data.pop_front() !== exp_data.pop_front()) bad++;
            end
            if (bad != 0) $display("FAIL %s_data got %0d bad beats want 0", name, bad);
            else pass_cnt++;
        end
        check_cnt++;
        if (rd_error !== want_err) $display("FAIL %s_rd_error got=%b want=%b", name, rd_error, want_err);
        else pass_cnt++;
        exp_ar.delete(); exp_data.delete();
    endtask

    task automatic test_size_edge();
        bit b_ok, d_ok;
        run_fetch(64'h9000, 0, 1'b1, b_ok, d_ok);
        check_cnt++;
        if (!d_ok || obs_ar.size() != 0 || obs_data.size() != 0)
            $display("FAIL zero_size done_ok=%0b ars=%0d beats=%0d want 1/0/0", d_ok, obs_ar.size(), obs_data.size());
        else pass_cnt++;
        check_cnt++;
        if (done_cyc != fetch_cyc + 2) $display("FAIL zero_size_latency got=%0d want=%0d", done_cyc - fetch_cyc, 2);
        else pass_cnt++;
        exp_ar.push_back('{64'h2000, 8'd1});
        test_multi("size33", 64'h2000, 33, 2, 1'b0);
    endtask

    task automatic test_ready_toggle();
        toggle_ready = 1'b1;
        rready_viol  = 0;
        exp_ar.push_back('{64'h3000, 8'd15});
        test_multi("toggle", 64'h3000, 512, 16, 1'b0);
        toggle_ready = 1'b0;
        check_cnt++;
        if (rready_viol != 0) $display("FAIL toggle_rready_follow got=%0d violations want=0", rready_viol);
        else pass_cnt++;
    endtask

    task automatic test_rlast_error();
        len_delta = -1;
        exp_ar.push_back('{64'h4000, 8'd3});
        exp_ar.push_back('{64'h4060, 8'd0});
        test_multi("rlast_early", 64'h4000, 128, 4, 1'b1);
        len_delta = 1;
        exp_ar.push_back('{64'h5000, 8'd1});
        test_multi("rlast_late", 64'h5000, 64, 3, 1'b1);
    endtask

    task automatic test_rresp();
        bit want;
`ifdef MEM_RD_RRESP_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        err_inject = 1'b1;
        exp_ar.push_back('{64'hA000, 8'd1});
        test_multi("rresp", 64'hA000, 64, 2, want);
        exp_ar.push_back('{64'hB000, 8'd0});
        test_multi("err_clear", 64'hB000, 32, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit b_ok, d_ok;
        run_fetch(64'h6000, 1024, 1'b0, b_ok, d_ok);
        for (int i = 0; i < 500 && obs_data.size() < 5; i++) begin
            @(negedge clk);
            #2;
        end
        check_cnt++;
        if (obs_data.size() < 5) $display("FAIL midreset_progress got=%0d beats want>=5", obs_data.size());
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_cnt++;
        if ({m_axi_arvalid, m_axi_rready, data_valid, data_read_done, busy, rd_error} !== 6'b0 ||
            m_axi_araddr !== '0 || m_axi_arlen !== 8'd0 || data_in !== '0)
            $display("FAIL midreset_outputs flags=%b araddr=0x%0h arlen=%0d", {m_axi_arvalid, m_axi_rready, data_valid, data_read_done, busy, rd_error}, m_axi_araddr, m_axi_arlen);
        else pass_cnt++;
        obs_ar.delete(); obs_data.delete();
        repeat (6) @(negedge clk);
        #2;
        check_cnt++;
        if (obs_ar.size() != 0 || obs_data.size() != 0 || busy !== 1'b0)
            $display("FAIL midreset_quiet ars=%0d beats=%0d busy=%b want 0/0/0", obs_ar.size(), obs_data.size(), busy);
        else pass_cnt++;
        exp_ar.push_back('{64'h7000, 8'd1});
        test_multi("after_reset", 64'h7000, 64, 2, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        fetch_data   = 1'b0;
        data_rd_addr = '0;
        data_rd_size = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        exp_ar.push_back('{64'h0, 8'd15});
        exp_ar.push_back('{64'h200, 8'd15});
        test_multi("two_bursts", 64'h0, 1024, 32, 1'b0);
        exp_ar.push_back('{64'hFC0, 8'd1});
        exp_ar.push_back('{64'h1000, 8'd5});
        test_multi("split_4k", 64'hFC0, 256, 8, 1'b0);
        test_size_edge();
        test_ready_toggle();
        test_rlast_error();
        test_rresp();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
